// File: rtl/ristretto_pkg.sv
// ============================================================================
// Module  : ristretto_pkg
// Brief   : Shared register-file sizing and writeback requester identifiers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ristretto_pkg;

  localparam int RegAddrWidth = 5;
  localparam int NumRegs      = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_req_e;

endpackage

`default_nettype wire

// File: rtl/ristretto_rf_scoreboard.sv
// ============================================================================
// Module  : ristretto_rf_scoreboard
// Brief   : Pending-write vector with set/clear and two hazard query ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ristretto_rf_scoreboard
  import ristretto_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    set_i,
  input  logic [RegAddrWidth-1:0] set_addr_i,
  input  logic                    clr_i,
  input  logic [RegAddrWidth-1:0] clr_addr_i,
  input  logic [RegAddrWidth-1:0] rs1_addr_i,
  input  logic [RegAddrWidth-1:0] rs2_addr_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o
);

  logic [NumRegs-1:0] r_pending;
  logic [NumRegs-1:0] w_pending_nxt;

  // Set is applied after clear so a re-issue wins over a retiring write.
  always_comb begin
    w_pending_nxt = r_pending;
    if (clr_i) w_pending_nxt[clr_addr_i] = 1'b0;
    if (set_i && (set_addr_i != '0)) w_pending_nxt[set_addr_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_pending <= '0;
    else         r_pending <= w_pending_nxt;
  end

  assign rs1_busy_o = (rs1_addr_i != '0) && r_pending[rs1_addr_i];
  assign rs2_busy_o = (rs2_addr_i != '0) && r_pending[rs2_addr_i];

endmodule

`default_nettype wire

// File: rtl/ristretto_rf_wb_arbiter.sv
// ============================================================================
// Module  : ristretto_rf_wb_arbiter
// Brief   : Arbitrates ALU/LSU writebacks onto one registered RF write port.
//           RISTRETTO_WB_RR_EN selects round-robin, else LSU fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ristretto_rf_wb_arbiter
  import ristretto_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    wb0_valid_i,
  output logic                    wb0_ready_o,
  input  logic [RegAddrWidth-1:0] wb0_addr_i,
  input  logic [DataWidth-1:0]    wb0_data_i,
  input  logic                    wb1_valid_i,
  output logic                    wb1_ready_o,
  input  logic [RegAddrWidth-1:0] wb1_addr_i,
  input  logic [DataWidth-1:0]    wb1_data_i,
  input  logic                    sb_set_i,
  input  logic [RegAddrWidth-1:0] sb_set_addr_i,
  input  logic [RegAddrWidth-1:0] sb_rs1_addr_i,
  input  logic [RegAddrWidth-1:0] sb_rs2_addr_i,
  output logic                    sb_rs1_busy_o,
  output logic                    sb_rs2_busy_o,
  output logic                    rf_wr_en_o,
  output logic [RegAddrWidth-1:0] rf_rd_addr_o,
  output logic [DataWidth-1:0]    rf_rd_wdata_o
);

  logic                    w_gnt_vld;
  wb_req_e                 w_gnt;
  logic [RegAddrWidth-1:0] w_addr;
  logic [DataWidth-1:0]    w_data;

  logic                    r_wr_en;
  logic [RegAddrWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_data;

  assign w_gnt_vld = wb0_valid_i | wb1_valid_i;

`ifdef RISTRETTO_WB_RR_EN
  wb_req_e r_prio;

  always_comb begin
    w_gnt = WB_ALU;
    if (wb0_valid_i && wb1_valid_i) w_gnt = r_prio;
    else if (wb1_valid_i)           w_gnt = WB_LSU;
  end

  // The loser of the last completed transfer is favoured next time.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        r_prio <= WB_ALU;
    else if (w_gnt_vld) r_prio <= (w_gnt == WB_ALU) ? WB_LSU : WB_ALU;
  end
`else
  assign w_gnt = wb1_valid_i ? WB_LSU : WB_ALU;
`endif

  assign wb0_ready_o = w_gnt_vld && (w_gnt == WB_ALU);
  assign wb1_ready_o = w_gnt_vld && (w_gnt == WB_LSU);

  assign w_addr = (w_gnt == WB_LSU) ? wb1_addr_i : wb0_addr_i;
  assign w_data = (w_gnt == WB_LSU) ? wb1_data_i : wb0_data_i;

  // x0 transfers are accepted and captured but never raise the write enable.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_wr_en <= w_gnt_vld && (w_addr != '0);
      if (w_gnt_vld) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign rf_wr_en_o    = r_wr_en;
  assign rf_rd_addr_o  = r_addr;
  assign rf_rd_wdata_o = r_data;

  ristretto_rf_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .set_i      (sb_set_i),
    .set_addr_i (sb_set_addr_i),
    .clr_i      (r_wr_en),
    .clr_addr_i (r_addr),
    .rs1_addr_i (sb_rs1_addr_i),
    .rs2_addr_i (sb_rs2_addr_i),
    .rs1_busy_o (sb_rs1_busy_o),
    .rs2_busy_o (sb_rs2_busy_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_ristretto_rf_wb_arbiter.sv
// ============================================================================
// Module  : tb_ristretto_rf_wb_arbiter
// Brief   : Randomized scoreboard bench with a behavioural arbiter/RF model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_ristretto_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        wb0_valid_i = 1'b0, wb1_valid_i = 1'b0;
  logic [4:0]  wb0_addr_i = '0, wb1_addr_i = '0;
  logic [31:0] wb0_data_i = '0, wb1_data_i = '0;
  logic        sb_set_i = 1'b0;
  logic [4:0]  sb_set_addr_i = '0, sb_rs1_addr_i = '0, sb_rs2_addr_i = '0;
  logic        wb0_ready_o, wb1_ready_o, sb_rs1_busy_o, sb_rs2_busy_o, rf_wr_en_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_wdata_o;

  ristretto_rf_wb_arbiter #(.DataWidth(32)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .wb0_valid_i(wb0_valid_i), .wb0_ready_o(wb0_ready_o),
    .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_ready_o(wb1_ready_o),
    .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
    .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i),
    .sb_rs1_addr_i(sb_rs1_addr_i), .sb_rs2_addr_i(sb_rs2_addr_i),
    .sb_rs1_busy_o(sb_rs1_busy_o), .sb_rs2_busy_o(sb_rs2_busy_o),
    .rf_wr_en_o(rf_wr_en_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_wdata_o(rf_rd_wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit         pend[32];
  int         last_winner;   // 0 = ALU, 1 = LSU; round-robin favours the other
  bit         inflight_v;
  logic [4:0] inflight_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    last_winner = 1;
    inflight_v  = 1'b0;
    inflight_a  = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, check combinational outputs mid-cycle, then
  // advance the model across the rising edge.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic set, input logic [4:0] sa,
                      input logic [4:0] r1, input logic [4:0] r2, output int gnt);
    logic       eb1, eb2;
    logic [4:0] ga;
    exp_t       e;
    wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
    wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
    sb_set_i = set; sb_set_addr_i = sa;
    sb_rs1_addr_i = r1; sb_rs2_addr_i = r2;
    if (v0 && v1) begin
`ifdef RISTRETTO_WB_RR_EN
      gnt = (last_winner == 0) ? 1 : 0;
`else
      gnt = 1;
`endif
    end else if (v1) gnt = 1;
    else if (v0)     gnt = 0;
    else             gnt = -1;
    eb1 = (r1 != 0) && pend[r1];
    eb2 = (r2 != 0) && pend[r2];
    @(negedge clk);
    chk("wb0_ready", {31'b0, wb0_ready_o}, {31'b0, gnt == 0});
    chk("wb1_ready", {31'b0, wb1_ready_o}, {31'b0, gnt == 1});
    chk("rs1_busy", {31'b0, sb_rs1_busy_o}, {31'b0, eb1});
    chk("rs2_busy", {31'b0, sb_rs2_busy_o}, {31'b0, eb2});
    @(posedge clk); #1;
    if (inflight_v) pend[inflight_a] = 1'b0;
    if (set && sa != 0) pend[sa] = 1'b1;
    inflight_v = 1'b0;
    if (gnt >= 0) begin
      last_winner = gnt;
      ga = (gnt == 1) ? a1 : a0;
      if (ga != 0) begin
        e.cyc = cyc; e.a = ga; e.d = (gnt == 1) ? d1 : d0;
        exp_q.push_back(e);
        inflight_v = 1'b1;
        inflight_a = ga;
      end
    end
  endtask

  // Monitor: every observed RF write must match the next expected write.
  exp_t m;
  always @(negedge clk) begin
    if (rstn_i) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        m = exp_q.pop_front();
        n_checks++; n_errs++;
        $display("FAIL missed_write: no write observed, expected addr %0d data %h in cycle %0d", m.a, m.d, m.cyc);
      end
      if (rf_wr_en_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected none (cycle %0d)", rf_rd_addr_o, rf_rd_wdata_o, cyc);
        end else begin
          m = exp_q.pop_front();
          if (m.cyc != cyc || m.a !== rf_rd_addr_o || m.d !== rf_rd_wdata_o) begin
            n_errs++;
            $display("FAIL rf_write: got addr %0d data %h cycle %0d, expected addr %0d data %h cycle %0d",
                     rf_rd_addr_o, rf_rd_wdata_o, cyc, m.a, m.d, m.cyc);
          end
        end
      end
    end
  end

  initial begin
    int g;
    logic       hv0, hv1;
    logic [4:0] ha0, ha1;
    logic [31:0] hd0, hd1;
    model_reset();
    #2;
    chk("reset_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    chk("reset_addr", {27'b0, rf_rd_addr_o}, 32'd0);
    chk("reset_data", rf_rd_wdata_o, 32'd0);
    @(negedge clk); @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk); #1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);  // idle: no ready
    // Conflict for four cycles
    for (int i = 0; i < 4; i++)
      step(1, 5'd3, 32'hAAAA_0000 + i, 1, 5'd4, 32'hBBBB_0000 + i, 0, 0, 0, 0, g);
    // Lone ALU writeback
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    // Pending set, query, retire
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, g);
    step(0, 0, 0, 1, 5'd7, 32'h7777, 0, 0, 5'd7, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, g);
    // Set and clear of the same index collide
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9, g);
    step(1, 5'd9, 32'h9999, 0, 0, 0, 0, 0, 5'd9, 0, g);
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, g);
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd9, 5'd0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0, g);
    // LSU write to x0
    step(0, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, g);
    chk("x0_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    hv0 = 0; hv1 = 0; ha0 = 0; ha1 = 0; hd0 = 0; hd1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!hv0 && $urandom_range(0, 2) != 0) begin
        hv0 = 1; ha0 = 5'($urandom_range(0, 31)); hd0 = $urandom;
      end
      if (!hv1 && $urandom_range(0, 2) != 0) begin
        hv1 = 1; ha1 = 5'($urandom_range(0, 31)); hd1 = $urandom;
      end
      step(hv0, ha0, hd0, hv1, ha1, hd1, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), g);
      if (g == 0) hv0 = 0;
      if (g == 1) hv1 = 0;
    end

    // Asynchronous reset while a write is on the RF port
    step(0, 0, 0, 0, 0, 0, 1, 5'd20, 0, 0, g);
    step(0, 0, 0, 0, 0, 0, 1, 5'd21, 0, 0, g);
    step(1, 5'd12, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, g);
    chk("pre_reset_wr_en", {31'b0, rf_wr_en_o}, 32'd1);
    #1 rstn_i = 1'b0;
    #0.5;
    chk("async_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    chk("async_addr", {27'b0, rf_rd_addr_o}, 32'd0);
    chk("async_data", rf_rd_wdata_o, 32'd0);
    for (int r = 1; r < 32; r += 2) begin
      sb_rs1_addr_i = 5'(r);
      sb_rs2_addr_i = 5'(r + 1);
      #0.1;
      chk("async_busy", {30'b0, sb_rs1_busy_o, sb_rs2_busy_o}, 32'd0);
    end
    model_reset();
    // No transfer completes while held in reset
    wb0_valid_i = 1; wb0_addr_i = 5'd15; wb0_data_i = 32'h5555;
    sb_set_i = 1; sb_set_addr_i = 5'd15; sb_rs1_addr_i = 5'd15;
    @(posedge clk); #1;
    chk("held_reset_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    wb0_valid_i = 0; sb_set_i = 0;
    @(negedge clk);
    chk("held_reset_busy", {31'b0, sb_rs1_busy_o}, 32'd0);
    rstn_i = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_wr_en", {31'b0, rf_wr_en_o}, 32'd0);

    for (int i = 0; i < 4; i++)
      step(1, 5'd1, 32'h1000 + i, 1, 5'd2, 32'h2000 + i, 0, 0, 5'd1, 5'd2, g);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
